pmem_responder: RTL
===================

PMEM_RESPONDER -- requirements
Module: pmem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 10, cycles from request acceptance to resp (legal range 1..255).
REQ-002 SHALL have parameter DEPTH_LINES, default 256, number of 256-bit lines stored (power of two, at least 2).
REQ-003 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port read  input  1  line read request from the initiator, held until resp.
REQ-006 SHALL have port write  input  1  line write request from the initiator, held until resp.
REQ-007 SHALL have port address  input  32  byte address of the line.
REQ-008 SHALL have port wdata  input  256  write line data.
REQ-009 SHALL have port resp  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rdata  output  256  read line data.
REQ-011 SHALL have port protocol_err  output  1  sticky protocol-violation flag.

Function
REQ-012 SHALL implement the states IDLE, WAIT and DONE.
REQ-013 In IDLE, exactly one of read or write high at edge T SHALL accept the request: latch the kind, index, and wdata; load the counter with LATENCY-1; go to WAIT.
REQ-014 Line index SHALL be address[5 +: log2(DEPTH_LINES)]; address[4:0] and the upper bits SHALL be ignored, so out-of-range addresses alias.
REQ-015 In WAIT, the counter SHALL decrement each cycle; resp SHALL be high for exactly the one cycle T+LATENCY.
REQ-016 A write SHALL commit the latched wdata to the latched index at the edge ending the resp cycle.
REQ-017 A read SHALL drive rdata with the latched line during the resp cycle; rdata SHALL hold that value until the next read resp.
REQ-018 After resp the FSM SHALL spend one cycle in DONE, ignore all requests there, then return to IDLE; the next acceptance is therefore no earlier than T+LATENCY+2.
REQ-019 address and wdata changes after acceptance SHALL have no effect on the in-flight request.
REQ-020 read and write both high in IDLE SHALL NOT be accepted, SHALL set protocol_err, and SHALL leave the FSM in IDLE.
REQ-021 In WAIT, the accepted request signal going low before resp SHALL abort: go to IDLE, no resp, no commit, and protocol_err set.
REQ-022 protocol_err SHALL remain set until reset.
REQ-023 A read of a never-written line SHALL return all zeros.

Reset
REQ-024 reset low at an edge SHALL force IDLE, resp=0, rdata=0, protocol_err=0, and counter=0.
REQ-025 Reset in WAIT SHALL discard the pending request: no resp and no commit.
REQ-026 Reset SHALL clear the storage array to zero; the clear may take DEPTH_LINES cycles, during which requests are not accepted and resp stays 0.

Structure
REQ-027 A shared package pmem_types SHALL hold:
- the LINE_WIDTH=256 and OFFSET_BITS=5 constants;
- the responder state enum (IDLE, WAIT, DONE).
REQ-028 Storage SHALL be a sub-module pmem_line_array with the following behaviour:
- one synchronous write port and one read port of 256 bits;
- DEPTH_LINES entries;
- reset-clear sequencing performed by the parent.
REQ-029 The FSM and counter SHALL live in pmem_responder; no other sub-modules are required.

Verification
REQ-030 Write then read, LATENCY=10:
- write=1, address=0x0000_0040, wdata=0xA5..A5 at T -> resp only at T+10;
- read of 0x0000_0040 accepted at T+12 -> resp at T+22 with rdata=0xA5..A5.
REQ-031 Aliasing, DEPTH_LINES=256: write 0x1234 to 0x0000_2000, then read 0x0000_0000 -> rdata=0x1234 and protocol_err=0.
REQ-032 Both requests high: read=write=1 in IDLE for 3 cycles -> no resp, protocol_err=1 from the next cycle, FSM stays in IDLE.
REQ-033 Abort: read accepted at T, read dropped at T+4 -> no resp ever and protocol_err=1; a new read at T+6 is accepted normally.
REQ-034 Reset mid-write: write accepted at T, reset=0 at T+3 -> no resp, and after the clear completes, a read of that line returns 0.
REQ-035 LATENCY=1 back-to-back reads -> resp at T+1, the next acceptance at T+3, and resp again at T+4.

Source files
------------

// File: rtl/pmem_types_pkg.sv
// Shared constants and state encoding for the line-memory responder.
// Imported by the responder and by its storage array.
package pmem_types;

    localparam int LINE_WIDTH  = 256;
    localparam int OFFSET_BITS = 5;
    localparam int ADDR_WIDTH  = 32;
    localparam int CNT_WIDTH   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pmem_line_array.sv
// Line storage: one synchronous write port and one registered read port.
// It has no reset; the parent zeroes it by sweeping the write port.
module pmem_line_array
    import pmem_types::*;
#(
    parameter int DEPTH_LINES = 256,
    localparam int IDX_W = $clog2(DEPTH_LINES)
) (
    input  logic                  clk,
    input  logic                  i_wen,
    input  logic [IDX_W-1:0]      i_waddr,
    input  logic [LINE_WIDTH-1:0] i_wdata,
    input  logic [IDX_W-1:0]      i_raddr,
    output logic [LINE_WIDTH-1:0] o_rdata
);

    logic [LINE_WIDTH-1:0] r_mem [DEPTH_LINES];
    logic [LINE_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_wen) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency line-memory responder: accepts one read or write, answers
// with a one-cycle resp after LATENCY cycles, and flags protocol violations.
module pmem_responder
    import pmem_types::*;
#(
    parameter int LATENCY     = 10,
    parameter int DEPTH_LINES = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [LINE_WIDTH-1:0] wdata,
    output logic                  resp,
    output logic [LINE_WIDTH-1:0] rdata,
    output logic                  protocol_err
);

    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(LATENCY - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_LINES - 1);

    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_counter;
    logic                  r_isWrite;
    logic [IDX_W-1:0]      r_index;
    logic [LINE_WIDTH-1:0] r_wdata;
    logic                  r_resp;
    logic [LINE_WIDTH-1:0] r_rdata;
    logic                  r_protocolErr;
    logic                  r_clearing;
    logic [IDX_W-1:0]      r_clearIdx;

    logic [IDX_W-1:0]      w_reqIndex;
    logic                  w_oneReq;
    logic                  w_bothReq;
    logic                  w_held;
    logic                  w_commit;
    logic                  w_arrWen;
    logic [IDX_W-1:0]      w_arrWaddr;
    logic [LINE_WIDTH-1:0] w_arrWdata;
    logic [IDX_W-1:0]      w_arrRaddr;
    logic [LINE_WIDTH-1:0] w_arrRdata;
    logic                  w_unusedAddr;

    // Offset and high address bits are dropped, so larger addresses alias.
    assign w_reqIndex   = address[OFFSET_BITS +: IDX_W];
    assign w_unusedAddr = ^{address[ADDR_WIDTH-1:OFFSET_BITS+IDX_W], address[OFFSET_BITS-1:0]};

    assign w_oneReq  = read ^ write;
    assign w_bothReq = read & write;
    assign w_held    = r_isWrite ? write : read;
    assign w_commit  = reset && (r_state == DONE) && r_isWrite;

    assign w_arrWen   = r_clearing | w_commit;
    assign w_arrWaddr = r_clearing ? r_clearIdx : r_index;
    assign w_arrWdata = r_clearing ? '0 : r_wdata;
    // In IDLE the read port looks at the incoming index so LATENCY=1 has data in time.
    assign w_arrRaddr = (r_state == IDLE) ? w_reqIndex : r_index;

    pmem_line_array #(
        .DEPTH_LINES (DEPTH_LINES)
    ) u_array (
        .clk     (clk),
        .i_wen   (w_arrWen),
        .i_waddr (w_arrWaddr),
        .i_wdata (w_arrWdata),
        .i_raddr (w_arrRaddr),
        .o_rdata (w_arrRdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_clearing <= 1'b1;
            r_clearIdx <= '0;
        end else if (r_clearing) begin
            r_clearIdx <= r_clearIdx + IDX_W'(1);
            if (r_clearIdx == LAST_IDX) begin
                r_clearing <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_counter     <= '0;
            r_isWrite     <= 1'b0;
            r_index       <= '0;
            r_wdata       <= '0;
            r_resp        <= 1'b0;
            r_rdata       <= '0;
            r_protocolErr <= 1'b0;
        end else begin
            r_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!r_clearing) begin
                        if (w_bothReq) begin
                            r_protocolErr <= 1'b1;
                        end else if (w_oneReq) begin
                            r_isWrite <= write;
                            r_index   <= w_reqIndex;
                            r_wdata   <= wdata;
                            r_counter <= CNT_LOAD;
                            r_state   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Dropping the request early is an abort, not a completion.
                    if (!w_held) begin
                        r_protocolErr <= 1'b1;
                        r_counter     <= '0;
                        r_state       <= IDLE;
                    end else if (r_counter == '0) begin
                        r_resp  <= 1'b1;
                        r_state <= DONE;
                        if (!r_isWrite) begin
                            r_rdata <= w_arrRdata;
                        end
                    end else begin
                        r_counter <= r_counter - CNT_WIDTH'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign resp         = r_resp;
    assign rdata        = r_rdata;
    assign protocol_err = r_protocolErr;

endmodule
